// File: rtl/writeback_stage_if.sv
// Bundle between the memory stage, the write-back stage and the register file.
// Memory-stage inputs plus stall/bubble in one direction, write ports in the other.
interface writeback_stage_if #(
  parameter int DATA_W = 64
);
  logic [3:0]        m_icode;
  logic [3:0]        m_rA;
  logic [3:0]        m_rB;
  logic              m_cnd;
  logic [DATA_W-1:0] m_valE;
  logic [DATA_W-1:0] m_valM;
  logic [2:0]        m_stat;
  logic              w_stall;
  logic              w_bubble;
  logic [3:0]        w_dstE;
  logic [3:0]        w_dstM;
  logic [DATA_W-1:0] w_valE;
  logic [DATA_W-1:0] w_valM;
  logic              w_weE;
  logic              w_weM;
  logic [3:0]        w_icode;
  logic [2:0]        w_stat;

  modport master (
    output m_icode, m_rA, m_rB, m_cnd,
    output m_valE, m_valM, m_stat,
    output w_stall, w_bubble,
    input  w_dstE, w_dstM, w_valE, w_valM,
    input  w_weE, w_weM, w_icode, w_stat
  );

  modport slave (
    input  m_icode, m_rA, m_rB, m_cnd,
    input  m_valE, m_valM, m_stat,
    input  w_stall, w_bubble,
    output w_dstE, w_dstM, w_valE, w_valM,
    output w_weE, w_weM, w_icode, w_stat
  );
endinterface

// File: rtl/writeback_stage.sv
// Y86-64 write-back stage: W register, dst decode, gated regfile enables,
// sticky halt/exception FSM and saturating retired-instruction counter.
module writeback_stage #(
  parameter int          DATA_W = 64,
  parameter logic [3:0]  RSP_ID = 4'd4,
  parameter logic [3:0]  RNONE  = 4'd15,
  parameter int          CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  writeback_stage_if.slave wb,
  output logic [2:0]       cpu_stat,
  output logic             halted,
  output logic [CNT_W-1:0] retired_count
);

  localparam logic [2:0] S_AOK = 3'd1;

  typedef enum logic {RUN, HALTED} state_e;

  typedef struct packed {
    logic [3:0]        icode;
    logic [3:0]        dstE;
    logic [3:0]        dstM;
    logic [DATA_W-1:0] valE;
    logic [DATA_W-1:0] valM;
    logic [2:0]        stat;
    logic              valid;
  } w_t;

  localparam w_t BUBBLE = '{
    icode: 4'd1, dstE: RNONE, dstM: RNONE,
    valE: '0, valM: '0, stat: S_AOK, valid: 1'b0
  };

  state_e           state_q, state_d;
  w_t               w_q, w_d;
  logic [2:0]       cpu_stat_q, cpu_stat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       dste, dstm;
  logic             is_cmov, is_rb, is_rsp;
  logic             run, w_aok;

  assign is_cmov = wb.m_icode == 4'd2;
  assign is_rb   = wb.m_icode == 4'd3
                || wb.m_icode == 4'd6;
  assign is_rsp  = wb.m_icode >= 4'd8
                && wb.m_icode <= 4'd11;

  always_comb begin
    dste = RNONE;
    unique case (1'b1)
      is_cmov: dste = wb.m_cnd ? wb.m_rB : RNONE;
      is_rb:   dste = wb.m_rB;
      is_rsp:  dste = RSP_ID;
      default: dste = RNONE;
    endcase
  end

  assign dstm = (wb.m_icode == 4'd5 || wb.m_icode == 4'd11)
              ? wb.m_rA : RNONE;

  assign run   = state_q == RUN;
  assign w_aok = w_q.stat == S_AOK;

  always_comb begin
    w_d = w_q;
    if (!run) begin
      w_d = w_q;
    end else if (wb.w_bubble) begin
      w_d = BUBBLE;
    end else if (!wb.w_stall) begin
      w_d = '{
        icode: wb.m_icode, dstE: dste, dstM: dstm,
        valE: wb.m_valE, valM: wb.m_valM,
        stat: wb.m_stat, valid: 1'b1
      };
    end
  end

  // The instruction in W that stops the machine is seen here one edge
  // after it enters W; its writes are already masked by w_aok.
  always_comb begin
    state_d    = state_q;
    cpu_stat_d = cpu_stat_q;
    if (run && w_q.valid && !w_aok) begin
      state_d    = HALTED;
      cpu_stat_d = w_q.stat;
    end
  end

  // Counted only when the instruction leaves W, so a stalled one
  // re-presenting its write is counted once.
  always_comb begin
    cnt_d = cnt_q;
    if (run && w_q.valid && w_aok && !wb.w_stall
        && cnt_q != {CNT_W{1'b1}})
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q        <= BUBBLE;
      state_q    <= RUN;
      cpu_stat_q <= S_AOK;
      cnt_q      <= '0;
    end else begin
      w_q        <= w_d;
      state_q    <= state_d;
      cpu_stat_q <= cpu_stat_d;
      cnt_q      <= cnt_d;
    end
  end

  // M port wins when both ports target the same register (popq %rsp).
  assign wb.w_weM = (w_q.dstM != RNONE) && w_aok && run;
  assign wb.w_weE = (w_q.dstE != RNONE) && w_aok && run
                 && (w_q.dstE != w_q.dstM);

  assign wb.w_dstE   = w_q.dstE;
  assign wb.w_dstM   = w_q.dstM;
  assign wb.w_valE   = w_q.valE;
  assign wb.w_valM   = w_q.valM;
  assign wb.w_icode  = w_q.icode;
  assign wb.w_stat   = w_q.stat;
  assign cpu_stat      = cpu_stat_q;
  assign halted        = !run;
  assign retired_count = cnt_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: scoreboard of expected W
// contents, one task per scenario.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cpu_stat;
  logic        halted;
  logic [31:0] retired_count;

  writeback_stage_if #(.DATA_W(64)) bus ();

  writeback_stage dut (
    .clk           (clk),
    .rst           (rst),
    .wb            (bus),
    .cpu_stat      (cpu_stat),
    .halted        (halted),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic        weE;
    logic        weM;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [2:0]  stat;
  } wb_t;

  wb_t sbq[$];
  wb_t e;
  int  errs   = 0;
  int  checks = 0;
  int  exp_cnt = 0;

  function automatic wb_t model(
    input logic [3:0] ic, ra, rb,
    input logic c,
    input logic [63:0] ve, vm,
    input logic [2:0] st);
    wb_t r;
    r.icode = ic;
    r.valE  = ve;
    r.valM  = vm;
    r.stat  = st;
    case (ic)
      4'd2:                    r.dstE = c ? rb : 4'd15;
      4'd3, 4'd6:              r.dstE = rb;
      4'd8, 4'd9, 4'd10, 4'd11: r.dstE = 4'd4;
      default:                 r.dstE = 4'd15;
    endcase
    r.dstM = (ic == 4'd5 || ic == 4'd11) ? ra : 4'd15;
    r.weM  = (r.dstM != 4'd15) && (st == 3'd1);
    r.weE  = (r.dstE != 4'd15) && (st == 3'd1)
          && (r.dstE != r.dstM);
    return r;
  endfunction

  function automatic wb_t obs();
    wb_t r;
    r.icode = bus.w_icode;
    r.dstE  = bus.w_dstE;
    r.dstM  = bus.w_dstM;
    r.weE   = bus.w_weE;
    r.weM   = bus.w_weM;
    r.valE  = bus.w_valE;
    r.valM  = bus.w_valM;
    r.stat  = bus.w_stat;
    return r;
  endfunction

  function automatic wb_t bubble_exp();
    wb_t r;
    r = '{icode: 4'd1, dstE: 4'd15, dstM: 4'd15, weE: 1'b0,
          weM: 1'b0, valE: 64'd0, valM: 64'd0, stat: 3'd1};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(
    input logic [3:0] ic, ra, rb,
    input logic c,
    input logic [63:0] ve, vm,
    input logic [2:0] st);
    bus.m_icode  = ic;
    bus.m_rA     = ra;
    bus.m_rB     = rb;
    bus.m_cnd    = c;
    bus.m_valE   = ve;
    bus.m_valM   = vm;
    bus.m_stat   = st;
    bus.w_bubble = 1'b0;
    bus.w_stall  = 1'b0;
  endtask

  task automatic drive(
    input logic [3:0] ic, ra, rb,
    input logic c,
    input logic [63:0] ve, vm,
    input logic [2:0] st);
    set_m(ic, ra, rb, c, ve, vm, st);
    sbq.push_back(model(ic, ra, rb, c, ve, vm, st));
  endtask

  task automatic idle();
    bus.w_bubble = 1'b1;
    bus.w_stall  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_m(4'd6, 4'd1, 4'd2, 1'b1, 64'hAA, 64'hBB, 3'd1);
    tick();
    tick();
    checks++;
    if ({bus.w_weE, bus.w_weM} !== 2'b00) begin
      errs++;
      $display("FAIL reset_we got=%b exp=00", {bus.w_weE, bus.w_weM});
    end
    checks++;
    if ({bus.w_dstE, bus.w_dstM} !== 8'hFF) begin
      errs++;
      $display("FAIL reset_dst got=%h exp=ff", {bus.w_dstE, bus.w_dstM});
    end
    checks++;
    if ({cpu_stat, halted} !== {3'd1, 1'b0}) begin
      errs++;
      $display("FAIL reset_stat got=%0d/%0d exp=1/0", cpu_stat, halted);
    end
    checks++;
    if (retired_count !== 32'd0) begin
      errs++;
      $display("FAIL reset_cnt got=%0d exp=0", retired_count);
    end
    rst = 1'b0;
    idle();
    tick();
    exp_cnt = 0;
  endtask

  task automatic test_irmovq();
    drive(4'd3, 4'd15, 4'd3, 1'b0, 64'h2A, 64'h0, 3'd1);
    tick();
    e = sbq.pop_front();
    checks++;
    if (obs() !== e) begin
      errs++;
      $display("FAIL irmovq_w got=%h exp=%h", obs(), e);
    end
    checks++;
    if (retired_count !== exp_cnt) begin
      errs++;
      $display("FAIL irmovq_cnt0 got=%0d exp=%0d", retired_count, exp_cnt);
    end
    idle();
    tick();
    exp_cnt++;
    checks++;
    if (retired_count !== exp_cnt) begin
      errs++;
      $display("FAIL irmovq_cnt1 got=%0d exp=%0d", retired_count, exp_cnt);
    end
  endtask

  task automatic test_cmov();
    for (int c = 0; c < 2; c++) begin
      drive(4'd2, 4'd1, 4'd2, c[0], 64'h1234, 64'h0, 3'd1);
      tick();
      e = sbq.pop_front();
      checks++;
      if (obs() !== e) begin
        errs++;
        $display("FAIL cmov_cnd%0d got=%h exp=%h", c, obs(), e);
      end
    end
    idle();
    tick();
    exp_cnt += 2;
    checks++;
    if (retired_count !== exp_cnt) begin
      errs++;
      $display("FAIL cmov_cnt got=%0d exp=%0d", retired_count, exp_cnt);
    end
  endtask

  task automatic test_popq();
    drive(4'd11, 4'd4, 4'd15, 1'b0, 64'h100, 64'h55, 3'd1);
    tick();
    e = sbq.pop_front();
    checks++;
    if (obs() !== e) begin
      errs++;
      $display("FAIL popq_rsp got=%h exp=%h", obs(), e);
    end
    checks++;
    if ({bus.w_weE, bus.w_weM} !== 2'b01) begin
      errs++;
      $display("FAIL popq_prio got=%b exp=01", {bus.w_weE, bus.w_weM});
    end
    idle();
    tick();
    exp_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] ic [11] = '{4'd6, 4'd5, 4'd10, 4'd8, 4'd9, 4'd4,
                            4'd7, 4'd1, 4'd5, 4'd11, 4'd3};
    logic [3:0] ra [11] = '{4'd1, 4'd7, 4'd2, 4'd15, 4'd15, 4'd1,
                            4'd15, 4'd15, 4'd4, 4'd6, 4'd15};
    logic [3:0] rb [11] = '{4'd5, 4'd3, 4'd15, 4'd15, 4'd15, 4'd2,
                            4'd15, 4'd15, 4'd0, 4'd15, 4'd15};
    for (int i = 0; i < 11; i++) begin
      drive(ic[i], ra[i], rb[i], 1'b1, 64'h1000 + 64'(i),
            64'h2000 + 64'(i * 3), 3'd1);
      tick();
      e = sbq.pop_front();
      checks++;
      if (obs() !== e) begin
        errs++;
        $display("FAIL b2b_%0d got=%h exp=%h", i, obs(), e);
      end
    end
    idle();
    tick();
    exp_cnt += 11;
    checks++;
    if (retired_count !== exp_cnt) begin
      errs++;
      $display("FAIL b2b_cnt got=%0d exp=%0d", retired_count, exp_cnt);
    end
  endtask

  task automatic test_stall();
    drive(4'd6, 4'd1, 4'd5, 1'b0, 64'h77, 64'h0, 3'd1);
    tick();
    e = sbq.pop_front();
    set_m(4'd3, 4'd15, 4'd1, 1'b0, 64'h99, 64'h0, 3'd1);
    bus.w_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (obs() !== e || retired_count !== exp_cnt) begin
        errs++;
        $display("FAIL stall_hold%0d got=%h/%0d exp=%h/%0d",
                 k, obs(), retired_count, e, exp_cnt);
      end
    end
    idle();
    tick();
    exp_cnt++;
    checks++;
    if (retired_count !== exp_cnt) begin
      errs++;
      $display("FAIL stall_once got=%0d exp=%0d", retired_count, exp_cnt);
    end
    drive(4'd6, 4'd2, 4'd7, 1'b0, 64'h88, 64'h0, 3'd1);
    tick();
    e = sbq.pop_front();
    bus.w_stall  = 1'b1;
    bus.w_bubble = 1'b1;
    tick();
    checks++;
    if (obs() !== bubble_exp() || retired_count !== exp_cnt) begin
      errs++;
      $display("FAIL stall_bubble got=%h/%0d exp=%h/%0d",
               obs(), retired_count, bubble_exp(), exp_cnt);
    end
    idle();
    tick();
  endtask

  task automatic test_halt();
    drive(4'd0, 4'd15, 4'd15, 1'b0, 64'h0, 64'h0, 3'd2);
    tick();
    e = sbq.pop_front();
    checks++;
    if (obs() !== e || halted !== 1'b0) begin
      errs++;
      $display("FAIL halt_w got=%h/%0d exp=%h/0", obs(), halted, e);
    end
    drive(4'd3, 4'd15, 4'd3, 1'b0, 64'hBEEF, 64'h0, 3'd1);
    tick();
    e = sbq.pop_front();
    e.weE = 1'b0;
    e.weM = 1'b0;
    checks++;
    if ({cpu_stat, halted} !== {3'd2, 1'b1}) begin
      errs++;
      $display("FAIL halt_state got=%0d/%0d exp=2/1", cpu_stat, halted);
    end
    checks++;
    if (obs() !== e) begin
      errs++;
      $display("FAIL halt_gate got=%h exp=%h", obs(), e);
    end
    set_m(4'd6, 4'd1, 4'd9, 1'b0, 64'h5, 64'h0, 3'd1);
    tick();
    tick();
    checks++;
    if (obs() !== e || retired_count !== exp_cnt || halted !== 1'b1) begin
      errs++;
      $display("FAIL halt_sticky got=%h/%0d/%0d exp=%h/%0d/1",
               obs(), retired_count, halted, e, exp_cnt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    exp_cnt = 0;
    checks++;
    if ({cpu_stat, halted} !== {3'd1, 1'b0} || retired_count !== 0) begin
      errs++;
      $display("FAIL halt_rst got=%0d/%0d/%0d exp=1/0/0",
               cpu_stat, halted, retired_count);
    end
  endtask

  task automatic test_exception();
    drive(4'd3, 4'd15, 4'd6, 1'b0, 64'h11, 64'h0, 3'd1);
    tick();
    void'(sbq.pop_front());
    drive(4'd5, 4'd7, 4'd2, 1'b0, 64'h40, 64'h66, 3'd3);
    tick();
    e = sbq.pop_front();
    exp_cnt++;
    checks++;
    if (obs() !== e || retired_count !== exp_cnt) begin
      errs++;
      $display("FAIL adr_w got=%h/%0d exp=%h/%0d",
               obs(), retired_count, e, exp_cnt);
    end
    idle();
    tick();
    checks++;
    if ({cpu_stat, halted} !== {3'd3, 1'b1}
        || retired_count !== exp_cnt) begin
      errs++;
      $display("FAIL adr_state got=%0d/%0d/%0d exp=3/1/%0d",
               cpu_stat, halted, retired_count, exp_cnt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({cpu_stat, halted} !== {3'd1, 1'b0}) begin
      errs++;
      $display("FAIL adr_rst got=%0d/%0d exp=1/0", cpu_stat, halted);
    end
  endtask

  initial begin
    rst = 1'b1;
    set_m(4'd1, 4'd15, 4'd15, 1'b0, 64'h0, 64'h0, 3'd1);
    idle();
    test_reset();
    test_irmovq();
    test_cmov();
    test_popq();
    test_back_to_back();
    test_stall();
    test_halt();
    test_exception();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
